// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared async FIFO constants and gray/binary conversions
package fifo_pkg;

    localparam int ADDRESS = 2;
    localparam int PTR_W   = ADDRESS + 1;
    localparam int DEPTH   = 2 ** ADDRESS;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended input keeps the MSB-down prefix valid for any narrower pointer.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - width-N two-flop synchronizer with synchronous reset
module sync_2ff #(
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] q1;

    always_ff @(posedge clk) begin
        if (reset) begin
            q1 <= '0;
            q  <= '0;
        end else begin
            q1 <= d;
            q  <= q1;
        end
    end

endmodule

// File: rtl/read_ptr_empty_logic.sv
// rtl/read_ptr_empty_logic.sv - async FIFO read pointer, empty/almost-empty, level and underflow
module read_ptr_empty_logic
    import fifo_pkg::*;
#(
    parameter int address   = ADDRESS,
    parameter int AE_THRESH = 1
) (
    input  logic             rclk,
    input  logic             rreset,
    input  logic             ren,
    input  logic [address:0] wptr_gray,
    output logic [address:0] read_ptr,
    output logic [address:0] rptr_gray,
    output logic [address-1:0] raddr,
    output logic             empty,
    output logic             almost_empty,
    output logic [address:0] level,
    output logic             rvalid,
    output logic             underflow
);

    localparam int PW = address + 1;
    localparam logic [PW-1:0] AE_T = PW'(AE_THRESH);

    logic [PW-1:0] wq2;
    logic [PW-1:0] wbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] level_next;
    logic          rd_ok;

    sync_2ff #(.N(PW)) u_wptr_sync (
        .clk   (rclk),
        .reset (rreset),
        .d     (wptr_gray),
        .q     (wq2)
    );

    always_comb begin
        rd_ok      = ren & ~empty;
        rbin_next  = read_ptr + PW'(rd_ok);
        rgray_next = PW'(bin2gray(32'(rbin_next)));
        wbin       = PW'(gray2bin(32'(wq2)));
        level_next = wbin - rbin_next;
    end

    // Empty is judged against the pointer after this edge's read, so the last read flags empty at once.
    always_ff @(posedge rclk) begin
        if (rreset) begin
            read_ptr     <= '0;
            rptr_gray    <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            level        <= '0;
            rvalid       <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            read_ptr     <= rbin_next;
            rptr_gray    <= rgray_next;
            empty        <= (rgray_next == wq2);
            almost_empty <= (level_next <= AE_T);
            level        <= level_next;
            rvalid       <= rd_ok;
            underflow    <= underflow | (ren & empty);
        end
    end

    assign raddr = read_ptr[address-1:0];

endmodule

// File: tb/tb_read_ptr_empty_logic.sv
// tb/tb_read_ptr_empty_logic.sv - self-checking bench for read_ptr_empty_logic
module tb_read_ptr_empty_logic;

    logic       rclk;
    logic       rreset;
    logic       ren;
    logic [2:0] wptr_gray;
    logic [2:0] read_ptr;
    logic [2:0] rptr_gray;
    logic [1:0] raddr;
    logic       empty;
    logic       almost_empty;
    logic [2:0] level;
    logic       rvalid;
    logic       underflow;

    int checks = 0;
    int passed = 0;

    // Reference model: counts of entries written/read, write count seen two edges late.
    int wcnt = 0;
    int m_rcnt = 0;
    int m_w1 = 0;
    int m_w2 = 0;
    int m_level = 0;
    bit m_empty = 1;
    bit m_ae = 1;
    bit m_rvalid = 0;
    bit m_uf = 0;

    read_ptr_empty_logic #(.address(2), .AE_THRESH(1)) dut (
        .rclk         (rclk),
        .rreset       (rreset),
        .ren          (ren),
        .wptr_gray    (wptr_gray),
        .read_ptr     (read_ptr),
        .rptr_gray    (rptr_gray),
        .raddr        (raddr),
        .empty        (empty),
        .almost_empty (almost_empty),
        .level        (level),
        .rvalid       (rvalid),
        .underflow    (underflow)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    function automatic logic [2:0] to_gray(input int n);
        int v;
        v = n % 8;
        return 3'(v ^ (v / 2));
    endfunction

    task automatic tick();
        bit rd;
        @(posedge rclk);
        if (rreset) begin
            m_rcnt = 0; m_w1 = 0; m_w2 = 0; m_level = 0;
            m_empty = 1; m_ae = 1; m_rvalid = 0; m_uf = 0;
        end else begin
            rd = ren && !m_empty;
            if (ren && m_empty) m_uf = 1;
            m_rcnt = m_rcnt + int'(rd);
            m_level = (((m_w2 - m_rcnt) % 8) + 8) % 8;
            m_empty = (m_level == 0);
            m_ae = (m_level <= 1);
            m_rvalid = rd;
            m_w2 = m_w1;
            m_w1 = wcnt % 8;
        end
        #1;
        wptr_gray = to_gray(wcnt);
    endtask

    task automatic do_reset();
        rreset = 1; ren = 0; wcnt = 0; wptr_gray = to_gray(0);
        tick();
        rreset = 0;
    endtask

    task automatic test_reset();
        rreset = 1; ren = 1; wcnt = 3; wptr_gray = to_gray(3);
        tick();
        tick();
        rreset = 0; ren = 0; wcnt = 0; wptr_gray = to_gray(0);
        checks++; if (empty !== 1'b1) $display("FAIL reset_empty got=%0b exp=1", empty); else passed++;
        checks++; if (almost_empty !== 1'b1) $display("FAIL reset_ae got=%0b exp=1", almost_empty); else passed++;
        checks++; if (read_ptr !== 3'd0) $display("FAIL reset_rptr got=%0d exp=0", read_ptr); else passed++;
        checks++; if (rptr_gray !== 3'd0) $display("FAIL reset_rgray got=%0d exp=0", rptr_gray); else passed++;
        checks++; if (level !== 3'd0) $display("FAIL reset_level got=%0d exp=0", level); else passed++;
        checks++; if (underflow !== 1'b0) $display("FAIL reset_underflow got=%0b exp=0", underflow); else passed++;
    endtask

    task automatic test_fill_latency();
        do_reset();
        wcnt = 1; wptr_gray = to_gray(1);
        tick();
        checks++; if (empty !== 1'b1) $display("FAIL fill_edge1_empty got=%0b exp=1", empty); else passed++;
        tick();
        checks++; if (empty !== 1'b1) $display("FAIL fill_edge2_empty got=%0b exp=1", empty); else passed++;
        tick();
        checks++; if (empty !== 1'b0) $display("FAIL fill_edge3_empty got=%0b exp=0", empty); else passed++;
        checks++; if (level !== 3'd1) $display("FAIL fill_level1 got=%0d exp=1", level); else passed++;
        checks++; if (almost_empty !== 1'b1) $display("FAIL fill_ae1 got=%0b exp=1", almost_empty); else passed++;
        wcnt = 2; wptr_gray = to_gray(2);
        repeat (3) tick();
        checks++; if (level !== 3'd2) $display("FAIL fill_level2 got=%0d exp=2", level); else passed++;
        checks++; if (almost_empty !== 1'b0) $display("FAIL fill_ae2 got=%0b exp=0", almost_empty); else passed++;
    endtask

    task automatic test_drain();
        checks++; if (raddr !== 2'd0) $display("FAIL drain_raddr0 got=%0d exp=0", raddr); else passed++;
        ren = 1;
        tick();
        checks++; if (read_ptr !== 3'd1) $display("FAIL drain_rptr1 got=%0d exp=1", read_ptr); else passed++;
        checks++; if (raddr !== 2'd1) $display("FAIL drain_raddr1 got=%0d exp=1", raddr); else passed++;
        checks++; if (rvalid !== 1'b1) $display("FAIL drain_rvalid1 got=%0b exp=1", rvalid); else passed++;
        checks++; if (empty !== 1'b0) $display("FAIL drain_empty1 got=%0b exp=0", empty); else passed++;
        tick();
        checks++; if (read_ptr !== 3'd2) $display("FAIL drain_rptr2 got=%0d exp=2", read_ptr); else passed++;
        checks++; if (empty !== 1'b1) $display("FAIL drain_empty2 got=%0b exp=1", empty); else passed++;
        checks++; if (rvalid !== 1'b1) $display("FAIL drain_rvalid2 got=%0b exp=1", rvalid); else passed++;
        tick();
        ren = 0;
        checks++; if (read_ptr !== 3'd2) $display("FAIL drain_rptr_hold got=%0d exp=2", read_ptr); else passed++;
        checks++; if (underflow !== 1'b1) $display("FAIL drain_underflow got=%0b exp=1", underflow); else passed++;
        checks++; if (rvalid !== 1'b0) $display("FAIL drain_rvalid3 got=%0b exp=0", rvalid); else passed++;
    endtask

    task automatic test_wrap();
        logic [2:0] exp_gray [8] = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
        int k;
        do_reset();
        k = 0;
        for (int pass = 0; pass < 2; pass++) begin
            wcnt = 4 * (pass + 1); wptr_gray = to_gray(wcnt);
            repeat (3) tick();
            checks++; if (level !== 3'd4) $display("FAIL wrap_level%0d got=%0d exp=4", pass, level); else passed++;
            checks++; if (empty !== 1'b0) $display("FAIL wrap_empty%0d got=%0b exp=0", pass, empty); else passed++;
            ren = 1;
            for (int i = 0; i < 4; i++) begin
                tick();
                checks++;
                if (rptr_gray !== exp_gray[k])
                    $display("FAIL wrap_rgray%0d got=%b exp=%b", k, rptr_gray, exp_gray[k]);
                else passed++;
                k++;
            end
            ren = 0;
            checks++; if (empty !== 1'b1) $display("FAIL wrap_drained%0d got=%0b exp=1", pass, empty); else passed++;
        end
        checks++; if (read_ptr !== 3'd0) $display("FAIL wrap_rptr got=%0d exp=0", read_ptr); else passed++;
    endtask

    task automatic test_mid_reset();
        do_reset();
        wcnt = 3; wptr_gray = to_gray(3);
        repeat (3) tick();
        checks++; if (level !== 3'd3) $display("FAIL midrst_level got=%0d exp=3", level); else passed++;
        ren = 1;
        tick();
        rreset = 1;
        tick();
        rreset = 0; wcnt = 0; wptr_gray = to_gray(0);
        checks++; if (read_ptr !== 3'd0) $display("FAIL midrst_rptr got=%0d exp=0", read_ptr); else passed++;
        checks++; if (empty !== 1'b1) $display("FAIL midrst_empty got=%0b exp=1", empty); else passed++;
        checks++; if (rvalid !== 1'b0) $display("FAIL midrst_rvalid got=%0b exp=0", rvalid); else passed++;
        checks++; if (underflow !== 1'b0) $display("FAIL midrst_underflow got=%0b exp=0", underflow); else passed++;
        ren = 0;
    endtask

    task automatic test_underflow_sticky();
        do_reset();
        ren = 1;
        tick();
        ren = 0;
        checks++; if (underflow !== 1'b1) $display("FAIL uf_set got=%0b exp=1", underflow); else passed++;
        checks++; if (read_ptr !== 3'd0) $display("FAIL uf_rptr got=%0d exp=0", read_ptr); else passed++;
        wcnt = 2; wptr_gray = to_gray(2);
        repeat (3) tick();
        ren = 1;
        repeat (2) tick();
        ren = 0;
        checks++; if (underflow !== 1'b1) $display("FAIL uf_sticky got=%0b exp=1", underflow); else passed++;
        checks++; if (read_ptr !== 3'd2) $display("FAIL uf_reads got=%0d exp=2", read_ptr); else passed++;
        rreset = 1;
        tick();
        rreset = 0; wcnt = 0; wptr_gray = to_gray(0);
        checks++; if (underflow !== 1'b0) $display("FAIL uf_clear got=%0b exp=0", underflow); else passed++;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            if ((wcnt - m_rcnt) < 4 && ($urandom % 2) == 1) wcnt++;
            wptr_gray = to_gray(wcnt);
            ren = (($urandom % 3) != 0);
            tick();
            checks++;
            if (read_ptr !== 3'(m_rcnt % 8)) $display("FAIL rnd_rptr c=%0d got=%0d exp=%0d", c, read_ptr, m_rcnt % 8);
            else passed++;
            checks++;
            if (rptr_gray !== to_gray(m_rcnt)) $display("FAIL rnd_rgray c=%0d got=%b exp=%b", c, rptr_gray, to_gray(m_rcnt));
            else passed++;
            checks++;
            if (empty !== m_empty) $display("FAIL rnd_empty c=%0d got=%0b exp=%0b", c, empty, m_empty);
            else passed++;
            checks++;
            if (level !== 3'(m_level)) $display("FAIL rnd_level c=%0d got=%0d exp=%0d", c, level, m_level);
            else passed++;
            checks++;
            if (almost_empty !== m_ae) $display("FAIL rnd_ae c=%0d got=%0b exp=%0b", c, almost_empty, m_ae);
            else passed++;
            checks++;
            if (rvalid !== m_rvalid) $display("FAIL rnd_rvalid c=%0d got=%0b exp=%0b", c, rvalid, m_rvalid);
            else passed++;
            checks++;
            if (underflow !== m_uf) $display("FAIL rnd_underflow c=%0d got=%0b exp=%0b", c, underflow, m_uf);
            else passed++;
        end
        ren = 0;
    endtask

    initial begin
        rreset = 1; ren = 0; wptr_gray = 3'b000;
        test_reset();
        test_fill_latency();
        test_drain();
        test_wrap();
        test_mid_reset();
        test_underflow_sticky();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
